alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Multi-cycle, width-parametrised ALU for the MIPS CPU datapath; successor to the single-cycle ALU.
- Keeps ADD, SUB, NOR and SLTU, and adds iterative unsigned multiply (MULTU) and divide (DIVU) with a HI/LO result.
- Uses a valid/ready handshake on both input and output, so the control unit can stall on long operations.
- Sits between the register-file read stage and write-back; results and flags are registered.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  clock, rising-edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept; equals (state==IDLE).
- alu_op  input  3  op code from alu_pkg.
- bus_a  input  WIDTH  operand A.
- bus_b  input  WIDTH  operand B.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- result_lo  output  WIDTH  main result / product low / quotient.
- result_hi  output  WIDTH  product high / remainder; 0 for single-cycle ops.
- zero  output  1  result_lo == 0.
- negative  output  1  result_lo[WIDTH-1].
- carryout  output  1  adder carry (ADD/SUB only, else 0).
- overflow  output  1  signed overflow (ADD/SUB only, else 0).
- div_zero  output  1  DIVU with bus_b == 0.
- illegal_op  output  1  alu_op is a reserved code.

Behaviour:
- Reset (reset_n=0 at clk edge):
  - state goes to IDLE.
  - All outputs and internal registers clear to 0; in_ready=1 once IDLE.
  - Reset mid-operation aborts it with no result produced.
- Accept: in_valid && in_ready at an edge latches alu_op, bus_a and bus_b. Operands are not sampled again.
- State machine: IDLE, CALC, DONE.
  - IDLE -> DONE on accept of ADD/SUB/NOR/SLTU/reserved. out_valid is high the cycle after accept (latency 1).
  - IDLE -> CALC on accept of MULTU/DIVU; counter loads WIDTH.
  - CALC decrements the counter each cycle; counter==1 -> DONE. out_valid rises WIDTH+1 cycles after accept.
  - DONE -> IDLE when out_ready=1. Results and flags hold stable while out_ready=0.
  - No accept is possible in DONE (in_ready=0), so throughput is at most one op per 2 cycles.
- Op rules:
  - ADD computes A+B.
  - SUB computes A+~B+1; carryout=1 means no borrow.
  - overflow = (A[msb]==B'[msb]) && (sum[msb]!=A[msb]), where B' is the adder's second operand (B for ADD, ~B for SUB).
  - NOR computes ~(A|B).
  - SLTU gives result_lo = {0..,!carry} of A-B. Flags zero/negative follow result_lo; carryout=overflow=0.
  - MULTU: shift-add, one partial product per cycle. {hi,lo} = A*B (2*WIDTH bits exact).
  - DIVU: restoring division, one quotient bit per cycle. lo = A/B, hi = A%B.
  - DIVU with B==0 still takes WIDTH+1 cycles; lo = all ones, hi = A, div_zero=1.
  - Reserved codes (110, 111): result 0, zero=1, illegal_op=1, latency 1.
- Flags (zero, negative, div_zero, illegal_op) are registered with the result and are valid only with out_valid. They are cleared on the next accept.
- Arithmetic is modulo 2^WIDTH except the MULTU product. There is no sign extension anywhere.

Decomposition:
- Package alu_pkg holds:
  - alu_op_t enum: ADD=3'b000, SUB=3'b001, NOR=3'b010, SLTU=3'b011, MULTU=3'b100, DIVU=3'b101.
  - alu_state_t: IDLE, CALC, DONE.
- Sub-module muldiv_iter (parameter WIDTH):
  - Holds the shared shift/accumulate registers and add/subtract step.
  - Controlled by load, step and mode from alu_mc.
  - Outputs hi/lo.
- Single-cycle ops and the FSM stay in alu_mc.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF+0x00000001 -> result_lo=0x80000000, overflow=1, negative=1, carryout=0, out_valid 1 cycle after accept. SUB 5-5 -> 0, zero=1, carryout=1.
- SLTU A=3, B=5 -> result_lo=1. SLTU A=0xFFFFFFFF, B=1 -> 0, zero=1. NOR 0,0 -> 0xFFFFFFFF, negative=1.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
- DIVU 100/7 -> lo=14, hi=2, div_zero=0. DIVU 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234, div_zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after a DIVU completes -> outputs stable, in_ready=0, in_valid ignored. Then out_ready=1 -> IDLE next cycle; a new ADD is accepted.
- Assert reset_n=0 for 1 cycle, 10 cycles into a MULTU -> all outputs 0, in_ready=1, no out_valid. A following MULTU 3*4 gives lo=12, hi=0. Reserved op 3'b111 -> illegal_op=1, result_lo=0.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared op codes and FSM state encoding for the multi-cycle MIPS ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        ADD   = 3'b000,
        SUB   = 3'b001,
        NOR   = 3'b010,
        SLTU  = 3'b011,
        MULTU = 3'b100,
        DIVU  = 3'b101
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MULTU) || (op == DIVU);
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the control unit (master) and the ALU (slave).
interface alu_mc_if #(
    parameter int WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] bus_a;
    logic [WIDTH-1:0] bus_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             negative;
    logic             carryout;
    logic             overflow;
    logic             div_zero;
    logic             illegal_op;

    modport master (
        output in_valid, alu_op, bus_a, bus_b, out_ready,
        input  in_ready, out_valid, result_lo, result_hi,
        input  zero, negative, carryout, overflow, div_zero, illegal_op
    );

    modport slave (
        input  in_valid, alu_op, bus_a, bus_b, out_ready,
        output in_ready, out_valid, result_lo, result_hi,
        output zero, negative, carryout, overflow, div_zero, illegal_op
    );

endinterface

// File: rtl/alu_mc_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide sharing one
// accumulator, one quotient/multiplier shift register and one adder.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             mode_i,   // 0: multiply, 1: divide
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q,  b_d;

    logic [WIDTH:0]   op1;
    logic [WIDTH:0]   op2;
    logic [WIDTH+1:0] sum;
    logic             no_borrow;

    // Multiply adds B (gated by the multiplier LSB) to the accumulator;
    // divide subtracts B from the shifted partial remainder. The extra top
    // bit of the sum is the borrow-free indication for the divide step.
    always_comb begin
        if (mode_i) begin
            op1 = {hi_q, lo_q[WIDTH-1]};
            op2 = ~{1'b0, b_q};
        end else begin
            op1 = {1'b0, hi_q};
            op2 = {1'b0, b_q & {WIDTH{lo_q[0]}}};
        end
        sum       = {1'b0, op1} + {1'b0, op2} + {{(WIDTH+1){1'b0}}, mode_i};
        no_borrow = sum[WIDTH+1];
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        b_d  = b_q;
        if (load_i) begin
            hi_d = '0;
            lo_d = a_i;
            b_d  = b_i;
        end else if (step_i) begin
            if (!mode_i) begin
                hi_d = sum[WIDTH:1];
                lo_d = {sum[0], lo_q[WIDTH-1:1]};
            end else if (no_borrow) begin
                hi_d = sum[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = op1[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            b_q  <= b_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ADD/SUB/NOR/SLTU plus iterative MULTU/DIVU,
// valid/ready handshake on request and result.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset_n,
    alu_mc_if.slave  io
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    alu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_md_q, is_md_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             dz_q, dz_d;
    logic             ill_q, ill_d;

    logic             accept;
    logic             md_load;
    logic             md_step;
    logic             md_sel;
    logic [WIDTH-1:0] md_hi, md_lo;

    logic             sub_sel;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [WIDTH-1:0] sc_lo;
    logic             sc_carry;
    logic             sc_ovf;
    logic             sc_ill;

    assign accept = io.in_valid && (state_q == IDLE);

    // SUB and SLTU share the adder with an inverted B and carry-in of 1.
    always_comb begin
        sub_sel     = (io.alu_op == SUB) || (io.alu_op == SLTU);
        b_op        = sub_sel ? ~io.bus_b : io.bus_b;
        {cout, sum} = {1'b0, io.bus_a} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub_sel};
    end

    always_comb begin
        sc_lo    = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_ill   = 1'b0;
        case (io.alu_op)
            ADD, SUB: begin
                sc_lo    = sum;
                sc_carry = cout;
                sc_ovf   = (io.bus_a[WIDTH-1] == b_op[WIDTH-1]) &&
                           (sum[WIDTH-1] != io.bus_a[WIDTH-1]);
            end
            NOR:       sc_lo = ~(io.bus_a | io.bus_b);
            SLTU:      sc_lo = {{(WIDTH-1){1'b0}}, ~cout};
            MULTU, DIVU: sc_lo = '0;
            default:   sc_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_md_d  = is_md_q;
        mode_d   = mode_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        dz_d     = dz_q;
        ill_d    = ill_q;
        md_load  = 1'b0;
        md_step  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    res_lo_d = sc_lo;
                    res_hi_d = '0;
                    zero_d   = (sc_lo == '0);
                    neg_d    = sc_lo[WIDTH-1];
                    carry_d  = sc_carry;
                    ovf_d    = sc_ovf;
                    ill_d    = sc_ill;
                    dz_d     = 1'b0;
                    is_md_d  = 1'b0;
                    mode_d   = 1'b0;
                    state_d  = DONE;
                    if (is_muldiv(io.alu_op)) begin
                        is_md_d = 1'b1;
                        mode_d  = (io.alu_op == DIVU);
                        dz_d    = (io.alu_op == DIVU) && (io.bus_b == '0);
                        md_load = 1'b1;
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                md_step = 1'b1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_md_q  <= 1'b0;
            mode_q   <= 1'b0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_md_q  <= is_md_d;
            mode_q   <= mode_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            dz_q     <= dz_d;
            ill_q    <= ill_d;
        end
    end

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (md_load),
        .step_i  (md_step),
        .mode_i  (mode_q),
        .a_i     (io.bus_a),
        .b_i     (io.bus_b),
        .hi_o    (md_hi),
        .lo_o    (md_lo)
    );

    // The iterative unit's own registers are the result once in DONE.
    assign md_sel        = is_md_q && (state_q == DONE);
    assign io.in_ready   = (state_q == IDLE);
    assign io.out_valid  = (state_q == DONE);
    assign io.result_lo  = md_sel ? md_lo : res_lo_q;
    assign io.result_hi  = md_sel ? md_hi : res_hi_q;
    assign io.zero       = md_sel ? (md_lo == '0) : zero_q;
    assign io.negative   = md_sel ? md_lo[WIDTH-1] : neg_q;
    assign io.carryout   = carry_q;
    assign io.overflow   = ovf_q;
    assign io.div_zero   = dz_q;
    assign io.illegal_op = ill_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=32.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (bus)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic accept_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.bus_a    = a;
        bus.bus_b    = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.bus_a    = ~a;
        bus.bus_b    = ~b;
    endtask

    task automatic wait_valid(output int lat, output logic busy_ok);
        lat     = 1;
        busy_ok = 1'b1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int   lat;
        logic busy_ok;
        logic stable;
        logic seen;

        bus.in_valid  = 1'b0;
        bus.alu_op    = 3'b000;
        bus.bus_a     = '0;
        bus.bus_b     = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk1("reset_in_ready", bus.in_ready, 1'b1);
        chk1("reset_out_valid", bus.out_valid, 1'b0);
        chk32("reset_lo", bus.result_lo, 32'h0);
        reset_n = 1'b1;

        accept_op(ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        wait_valid(lat, busy_ok);
        chk32("add_latency", 32'(lat), 32'd1);
        chk32("add_lo", bus.result_lo, 32'h8000_0000);
        chk1("add_ovf", bus.overflow, 1'b1);
        chk1("add_neg", bus.negative, 1'b1);
        chk1("add_carry", bus.carryout, 1'b0);
        chk1("add_zero", bus.zero, 1'b0);
        retire();

        accept_op(SUB, 32'd5, 32'd5);
        wait_valid(lat, busy_ok);
        chk32("sub_lo", bus.result_lo, 32'h0);
        chk1("sub_zero", bus.zero, 1'b1);
        chk1("sub_carry", bus.carryout, 1'b1);
        chk1("sub_ovf", bus.overflow, 1'b0);
        retire();

        accept_op(SLTU, 32'd3, 32'd5);
        wait_valid(lat, busy_ok);
        chk32("sltu_lt_lo", bus.result_lo, 32'h1);
        chk1("sltu_lt_carry", bus.carryout, 1'b0);
        retire();

        accept_op(SLTU, 32'hFFFF_FFFF, 32'd1);
        wait_valid(lat, busy_ok);
        chk32("sltu_ge_lo", bus.result_lo, 32'h0);
        chk1("sltu_ge_zero", bus.zero, 1'b1);
        retire();

        accept_op(NOR, 32'h0, 32'h0);
        wait_valid(lat, busy_ok);
        chk32("nor_lo", bus.result_lo, 32'hFFFF_FFFF);
        chk1("nor_neg", bus.negative, 1'b1);
        retire();

        accept_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_valid(lat, busy_ok);
        chk32("multu_latency", 32'(lat), 32'd33);
        chk1("multu_busy", busy_ok, 1'b1);
        chk32("multu_hi", bus.result_hi, 32'hFFFF_FFFE);
        chk32("multu_lo", bus.result_lo, 32'h0000_0001);
        retire();

        accept_op(DIVU, 32'd100, 32'd7);
        wait_valid(lat, busy_ok);
        chk32("divu_latency", 32'(lat), 32'd33);
        chk32("divu_lo", bus.result_lo, 32'd14);
        chk32("divu_hi", bus.result_hi, 32'd2);
        chk1("divu_dz", bus.div_zero, 1'b0);
        retire();

        accept_op(DIVU, 32'h1234, 32'h0);
        wait_valid(lat, busy_ok);
        chk32("div0_latency", 32'(lat), 32'd33);
        chk32("div0_lo", bus.result_lo, 32'hFFFF_FFFF);
        chk32("div0_hi", bus.result_hi, 32'h1234);
        chk1("div0_dz", bus.div_zero, 1'b1);

        stable = 1'b1;
        bus.in_valid = 1'b1;
        bus.alu_op   = ADD;
        bus.bus_a    = 32'd1;
        bus.bus_b    = 32'd1;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.result_lo !== 32'hFFFF_FFFF || bus.result_hi !== 32'h1234 ||
                bus.div_zero !== 1'b1 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                stable = 1'b0;
        end
        bus.in_valid = 1'b0;
        chk1("backpressure_stable", stable, 1'b1);
        retire();
        chk1("retire_in_ready", bus.in_ready, 1'b1);
        chk1("retire_out_valid", bus.out_valid, 1'b0);

        accept_op(ADD, 32'd2, 32'd3);
        wait_valid(lat, busy_ok);
        chk32("add2_latency", 32'(lat), 32'd1);
        chk32("add2_lo", bus.result_lo, 32'd5);
        chk1("add2_dz_cleared", bus.div_zero, 1'b0);
        retire();

        accept_op(MULTU, 32'd7, 32'd9);
        repeat (10) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk32("abort_lo", bus.result_lo, 32'h0);
        chk32("abort_hi", bus.result_hi, 32'h0);
        chk1("abort_in_ready", bus.in_ready, 1'b1);
        chk1("abort_out_valid", bus.out_valid, 1'b0);
        chk1("abort_dz", bus.div_zero, 1'b0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        chk1("abort_no_result", seen, 1'b0);

        accept_op(MULTU, 32'd3, 32'd4);
        wait_valid(lat, busy_ok);
        chk32("mul34_lo", bus.result_lo, 32'd12);
        chk32("mul34_hi", bus.result_hi, 32'd0);
        retire();

        accept_op(3'b111, 32'h55, 32'hAA);
        wait_valid(lat, busy_ok);
        chk32("illegal_latency", 32'(lat), 32'd1);
        chk1("illegal_flag", bus.illegal_op, 1'b1);
        chk32("illegal_lo", bus.result_lo, 32'h0);
        chk1("illegal_zero", bus.zero, 1'b1);
        retire();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
